// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg -- state, opcode, mux-select and ALU encodings for mc_controller. rev 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNE      = 4'd12
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OP    = 2'b11;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/aludec.sv
// ============================================================================
// aludec -- ALU control decode from aluop, R-type funct and immediate opcode. rev 1.0
// ============================================================================
`default_nettype none

module aludec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [4:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      // Immediate logic ops decode straight from the opcode.
      ALUOP_OP: begin
        case (op)
          6'b001100: alucontrol = ALU_AND;
          6'b001101: alucontrol = ALU_OR;
          6'b001010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_mainfsm.sv
// ============================================================================
// mc_mainfsm -- Moore sequencer for the multicycle datapath (MC_BNE_EN adds BNE). rev 1.0
// ============================================================================
`default_nettype none

module mc_mainfsm
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       branch,
  output logic       branchne,
  output logic       pcwrite,
  output logic       legal
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = FETCH;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    branch   = 1'b0;
    branchne = 1'b0;
    pcwrite  = 1'b0;
    legal    = 1'b1;
    case (state_q)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      // Same datapath as BRANCH; only the sense of zero used for pcen flips.
      BNE: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branchne = 1'b1;
      end
`endif
      default: begin
        legal   = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller -- multicycle MIPS control unit; define MC_BNE_EN to add bne. rev 1.0
// ============================================================================
`default_nettype none

module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [4:0] alucontrol
);

  logic       fsm_memwrite;
  logic       fsm_irwrite;
  logic       fsm_regwrite;
  logic [1:0] aluop;
  logic       branch;
  logic       branchne;
  logic       pcwrite;
  logic       legal;
  logic [4:0] dec_alucontrol;

  mc_mainfsm #(
    .STATE_W (STATE_W)
  ) u_mainfsm (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .iord     (iord),
    .memwrite (fsm_memwrite),
    .irwrite  (fsm_irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (fsm_regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .branch   (branch),
    .branchne (branchne),
    .pcwrite  (pcwrite),
    .legal    (legal)
  );

  aludec u_aludec (
    .op         (op),
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (dec_alucontrol)
  );

  // Architectural writes are held off for the whole reset pulse, not just the edge.
  assign irwrite    = fsm_irwrite  & ~reset;
  assign regwrite   = fsm_regwrite & ~reset;
  assign memwrite   = fsm_memwrite & ~reset;
  assign pcen       = ~reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign alucontrol = legal ? dec_alucontrol : 5'b00000;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller -- directed per-cycle output checks for mc_controller. rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [4:0] alucontrol;
  logic [11:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol)
  );

  assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, pcen};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ov(input logic io, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic pce);
    return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, pce};
  endfunction

  // Advance one clock edge and check the outputs of the state just entered.
  task automatic step_check(input string tag, input logic [11:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, {20'd0, obs}, {20'd0, exp});
  endtask

  logic [11:0] s_rst, s_fetch, s_decode, s_memadr, s_memrd, s_memwb, s_memwr;
  logic [11:0] s_exec, s_aluwb, s_br_t, s_br_n, s_addiwb, s_jump;

  initial begin
    s_rst    = ov(0,0,0,0,0,0,0,2'b01,2'b00,0);
    s_fetch  = ov(0,0,1,0,0,0,0,2'b01,2'b00,1);
    s_decode = ov(0,0,0,0,0,0,0,2'b11,2'b00,0);
    s_memadr = ov(0,0,0,0,0,0,1,2'b10,2'b00,0);
    s_memrd  = ov(1,0,0,0,0,0,0,2'b00,2'b00,0);
    s_memwb  = ov(0,0,0,0,1,1,0,2'b00,2'b00,0);
    s_memwr  = ov(1,1,0,0,0,0,0,2'b00,2'b00,0);
    s_exec   = ov(0,0,0,0,0,0,1,2'b00,2'b00,0);
    s_aluwb  = ov(0,0,0,1,0,1,0,2'b00,2'b00,0);
    s_br_t   = ov(0,0,0,0,0,0,1,2'b00,2'b01,1);
    s_br_n   = ov(0,0,0,0,0,0,1,2'b00,2'b01,0);
    s_addiwb = ov(0,0,0,0,0,1,0,2'b00,2'b00,0);
    s_jump   = ov(0,0,0,0,0,0,0,2'b00,2'b10,1);

    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    #1;
    check_eq("reset_outputs", {20'd0, obs}, {20'd0, s_rst});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("lw_fetch", {20'd0, obs}, {20'd0, s_fetch});
    check_eq("fetch_aluctl", {27'd0, alucontrol}, 32'h02);

    // lw: 5 cycles
    step_check("lw_decode", s_decode);
    check_eq("decode_aluctl", {27'd0, alucontrol}, 32'h02);
    step_check("lw_memadr", s_memadr);
    step_check("lw_memrd", s_memrd);
    step_check("lw_memwb", s_memwb);
    step_check("lw_next_fetch", s_fetch);

    // beq taken then not taken: 3 cycles each
    op   = 6'b000100;
    zero = 1'b1;
    step_check("beqt_decode", s_decode);
    step_check("beqt_branch", s_br_t);
    check_eq("beq_aluctl", {27'd0, alucontrol}, 32'h06);
    step_check("beqt_fetch", s_fetch);
    zero = 1'b0;
    step_check("beqn_decode", s_decode);
    step_check("beqn_branch", s_br_n);
    step_check("beqn_fetch", s_fetch);

    // R-type add and or: 4 cycles
    op    = 6'b000000;
    funct = 6'b100000;
    step_check("add_decode", s_decode);
    step_check("add_execute", s_exec);
    check_eq("add_aluctl", {27'd0, alucontrol}, 32'h02);
    step_check("add_aluwb", s_aluwb);
    step_check("add_fetch", s_fetch);
    funct = 6'b100101;
    step_check("or_decode", s_decode);
    step_check("or_execute", s_exec);
    check_eq("or_aluctl", {27'd0, alucontrol}, 32'h01);
    step_check("or_aluwb", s_aluwb);
    step_check("or_fetch", s_fetch);

    // addi: 4 cycles
    op = 6'b001000;
    step_check("addi_decode", s_decode);
    step_check("addi_exec", s_memadr);
    step_check("addi_wb", s_addiwb);
    step_check("addi_fetch", s_fetch);

    // j: 3 cycles
    op = 6'b000010;
    step_check("j_decode", s_decode);
    step_check("j_jump", s_jump);
    step_check("j_fetch", s_fetch);

    // unknown opcode: 2 cycles, no writes
    op = 6'b111111;
    step_check("unk_decode", s_decode);
    step_check("unk_fetch", s_fetch);

    op   = 6'b000101;
    zero = 1'b0;
`ifdef MC_BNE_EN
    step_check("bne_decode", s_decode);
    step_check("bne_state", s_br_t);
    step_check("bne_fetch", s_fetch);
`else
    step_check("bne_off_decode", s_decode);
    step_check("bne_off_fetch", s_fetch);
`endif

    // sw, then asynchronous reset in the middle of MEMWR
    op = 6'b101011;
    step_check("sw_decode", s_decode);
    step_check("sw_memadr", s_memadr);
    step_check("sw_memwr", s_memwr);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset", {20'd0, obs}, {20'd0, s_rst});
    step_check("reset_hold", s_rst);
    reset = 1'b0;
    #1;
    check_eq("post_reset_fetch", {20'd0, obs}, {20'd0, s_fetch});
    step_check("post_reset_decode", s_decode);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
